captura_adc: RTL and testbench
==============================

CAPTURA_ADC -- requirements
Module: captura_adc

Interface
REQ-001 The block SHALL expose parameter W, default 12, meaning the sample width delivered downstream.
REQ-002 The block SHALL expose parameter DIV, default 2, meaning the number of CLK cycles per SCLK half-period; legal range is 1..15.
REQ-003 Port CLK, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port Iniciar, input, 1 bit: conversion request, sampled only in REPOSO.
REQ-006 Port SDATA, input, 1 bit: serial data from the ADC, MSB first.
REQ-007 Port SCLK, output, 1 bit: serial clock to the ADC, registered, idle high.
REQ-008 Port CS_n, output, 1 bit: ADC chip select, registered, active low.
REQ-009 Port Ocupado, output, 1 bit: a conversion is in progress.
REQ-010 Port Dato, output, W bits: last captured sample; feeds the Entrada of the downstream 12-bit register.
REQ-011 Port Listo, output, 1 bit: one-cycle strobe that Dato is new; drives the downstream register's Enable.

Function
REQ-012 The FSM SHALL have five states: REPOSO, ESPERA, TRANSFERENCIA, FIN and SILENCIO.
REQ-013 In REPOSO, Iniciar high at an edge (edge 0) SHALL move the FSM to ESPERA, with CS_n low and Ocupado high after that edge.
REQ-014 ESPERA SHALL last DIV cycles with SCLK high, then enter TRANSFERENCIA.
REQ-015 TRANSFERENCIA SHALL produce 16 SCLK periods, each DIV cycles low then DIV cycles high, for 32*DIV cycles total.
REQ-016 SDATA SHALL be shifted into a 16-bit shift register at each edge where SCLK is driven low-to-high.
REQ-017 After the 16th sample the FSM SHALL enter FIN.
REQ-018 In FIN, Dato SHALL load shift bits [11:0], discarding the 4 leading bits regardless of their value.
REQ-019 In FIN, Listo SHALL be high for exactly one cycle, the cycle between edges 33*DIV and 33*DIV+1 (edges 66 to 67 for DIV=2), and CS_n SHALL rise at its end.
REQ-020 SILENCIO SHALL hold CS_n high for DIV cycles, then return to REPOSO; Ocupado SHALL drop on entry to REPOSO.
REQ-021 With Iniciar held high, conversions SHALL start every 34*DIV+2 cycles (70 for DIV=2).
REQ-022 Iniciar SHALL be ignored in every state except REPOSO; no request is queued.
REQ-023 Dato SHALL hold its value between Listo strobes, and Listo SHALL never be high for two consecutive cycles.
REQ-024 The bit counter SHALL be 5 bits and the divider counter 4 bits, with no wrap-around beyond terminal counts.

Reset
REQ-025 Reset high SHALL immediately, without waiting for CLK, force: FSM to REPOSO, CS_n=1, SCLK=1, Ocupado=0, Listo=0, Dato=0, counters=0, shift register=0.
REQ-026 Reset asserted mid-transfer SHALL abort the conversion and produce no Listo pulse.
REQ-027 After Reset is released, the first Iniciar SHALL behave exactly as in REQ-013.

Structure
REQ-028 A shared package SHALL hold the state encoding, N_BITS=16 and LEAD=4.
REQ-029 The 16-bit serial-in shift register SHALL be one sub-module, registro_desplazamiento; FSM and counters remain in captura_adc.

Verification
REQ-030 ADC model sends 0000_1010_1100_0011 with DIV=2, Iniciar pulsed once -> Dato=12'hAC3 and Listo high only during cycle 66-67.
REQ-031 ADC model sends 1111_0000_0000_0001 -> Dato=12'h001 (leading bits ignored).
REQ-032 Iniciar re-pulsed at cycles 5 and 40 of a conversion -> exactly one Listo, and exactly 16 SCLK rising edges while CS_n is low.
REQ-033 Iniciar held high for 3 conversions (samples 12'hFFF, 12'h000, 12'h555) -> Listo at cycles 66, 136 and 206 with matching Dato.
REQ-034 Reset asserted asynchronously at cycle 30 -> CS_n=1, SCLK=1, Dato=0 within the same cycle, and no Listo afterwards.
REQ-035 DIV=1 with sample 12'h7FF -> Listo at cycle 33 and Dato=12'h7FF.

Source files
------------

// File: rtl/captura_adc_pkg.sv
// Shared definitions for the serial ADC capture block: FSM encoding and
// frame geometry (16-bit frame, 4 leading bits discarded).
package captura_adc_pkg;

  localparam int N_BITS = 16;
  localparam int LEAD   = 4;

  typedef enum logic [2:0] {
    REPOSO        = 3'd0,
    ESPERA        = 3'd1,
    TRANSFERENCIA = 3'd2,
    FIN           = 3'd3,
    SILENCIO      = 3'd4
  } estado_t;

endpackage

// File: rtl/captura_adc_registro_desplazamiento.sv
// Serial-in, parallel-out shift register; MSB arrives first, so new bits
// enter at bit 0 and older bits move toward the top.
module registro_desplazamiento #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         din,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {q[N-2:0], din};
    end
  end

endmodule

// File: rtl/captura_adc.sv
// SPI-style capture of a 16-bit ADC frame: drives SCLK/CS_n, shifts SDATA in
// on each SCLK rise and presents the low 12 bits on Dato with a Listo strobe.
module captura_adc
  import captura_adc_pkg::*;
#(
  parameter int W   = 12,
  parameter int DIV = 2
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Iniciar,
  input  logic         SDATA,
  output logic         SCLK,
  output logic         CS_n,
  output logic         Ocupado,
  output logic [W-1:0] Dato,
  output logic         Listo,
  output estado_t      estado
);

  localparam logic [3:0] DIV_FIN  = 4'(DIV - 1);
  localparam logic [4:0] BITS_FIN = 5'(N_BITS);

  estado_t            estado_q, estado_d;
  logic [3:0]         div_q, div_d;
  logic [4:0]         bit_q, bit_d;
  logic               sclk_q, sclk_d;
  logic               cs_q, cs_d;
  logic               shift_en;
  logic               carga;
  logic               div_fin;
  logic [N_BITS-1:0]  shift_q;
  logic [W-1:0]       dato_q;
  logic               cabecera_unused;

  registro_desplazamiento #(.N(N_BITS)) u_shift (
    .clk (CLK),
    .rst (Reset),
    .en  (shift_en),
    .din (SDATA),
    .q   (shift_q)
  );

  // The leading bits of the frame carry no sample information.
  assign cabecera_unused = ^shift_q[N_BITS-1:N_BITS-LEAD];

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      estado_q <= REPOSO;
      div_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b1;
      cs_q     <= 1'b1;
      dato_q   <= '0;
    end else begin
      estado_q <= estado_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      if (carga) begin
        dato_q <= W'(shift_q[N_BITS-LEAD-1:0]);
      end
    end
  end

  always_comb begin
    estado_d = estado_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    shift_en = 1'b0;
    carga    = 1'b0;
    div_fin  = (div_q == DIV_FIN);

    case (estado_q)
      REPOSO: begin
        div_d  = '0;
        bit_d  = '0;
        sclk_d = 1'b1;
        cs_d   = 1'b1;
        if (Iniciar) begin
          estado_d = ESPERA;
          cs_d     = 1'b0;
        end
      end
      ESPERA: begin
        if (div_fin) begin
          div_d    = '0;
          sclk_d   = 1'b0;
          estado_d = TRANSFERENCIA;
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      TRANSFERENCIA: begin
        // Each half-period ends on div_fin; a low half ends in a rising SCLK
        // (sample point), a high half either starts the next bit or ends the frame.
        if (div_fin) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d   = 1'b1;
            shift_en = 1'b1;
            bit_d    = bit_q + 5'd1;
          end else if (bit_q == BITS_FIN) begin
            estado_d = FIN;
            carga    = 1'b1;
          end else begin
            sclk_d = 1'b0;
          end
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      FIN: begin
        div_d    = '0;
        cs_d     = 1'b1;
        estado_d = SILENCIO;
      end
      SILENCIO: begin
        if (div_fin) begin
          div_d    = '0;
          estado_d = REPOSO;
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  assign SCLK    = sclk_q;
  assign CS_n    = cs_q;
  assign Dato    = dato_q;
  assign Listo   = (estado_q == FIN);
  assign Ocupado = (estado_q != REPOSO);
  assign estado  = estado_q;

endmodule

// File: tb/tb_captura_adc.sv
// Bench for captura_adc: one instance with DIV=2 and one with DIV=1, each fed
// by a behavioural ADC that shifts a 16-bit word out on falling SCLK.
module tb_captura_adc;
  import captura_adc_pkg::*;

  logic          clk;
  logic          rst   [2];
  logic          ini   [2];
  logic          sclk  [2];
  logic          cs_n  [2];
  logic          ocup  [2];
  logic          listo [2];
  logic [11:0]   dato  [2];
  estado_t       est   [2];
  logic          sdata0 = 1'b0;
  logic          sdata1 = 1'b0;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  // Scoreboard: expected Dato values and the absolute edge at which Listo shows them.
  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];
  int          t_q0[$];
  int          t_q1[$];
  logic [15:0] adc_q0[$];
  logic [15:0] adc_q1[$];

  logic        prev_listo [2];
  logic [11:0] held       [2];
  logic [15:0] word0 = '0;
  logic [15:0] word1 = '0;
  int          idx0 = 16;
  int          idx1 = 16;
  int          rises0 = 0;
  int          rises1 = 0;

  captura_adc #(.W(12), .DIV(2)) dut_d2 (
    .CLK(clk), .Reset(rst[0]), .Iniciar(ini[0]), .SDATA(sdata0),
    .SCLK(sclk[0]), .CS_n(cs_n[0]), .Ocupado(ocup[0]), .Dato(dato[0]),
    .Listo(listo[0]), .estado(est[0])
  );

  captura_adc #(.W(12), .DIV(1)) dut_d1 (
    .CLK(clk), .Reset(rst[1]), .Iniciar(ini[1]), .SDATA(sdata1),
    .SCLK(sclk[1]), .CS_n(cs_n[1]), .Ocupado(ocup[1]), .Dato(dato[1]),
    .Listo(listo[1]), .estado(est[1])
  );

  // Clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ADC models: next bit appears after every falling SCLK while selected.
  always @(negedge sclk[0] or posedge cs_n[0]) begin
    if (cs_n[0] === 1'b1) begin
      idx0 = 16;
    end else if (cs_n[0] === 1'b0 && idx0 > 0) begin
      if (idx0 == 16) word0 = (adc_q0.size() > 0) ? adc_q0.pop_front() : 16'h0;
      idx0--;
      sdata0 = word0[idx0];
    end
  end

  always @(negedge sclk[1] or posedge cs_n[1]) begin
    if (cs_n[1] === 1'b1) begin
      idx1 = 16;
    end else if (cs_n[1] === 1'b0 && idx1 > 0) begin
      if (idx1 == 16) word1 = (adc_q1.size() > 0) ? adc_q1.pop_front() : 16'h0;
      idx1--;
      sdata1 = word1[idx1];
    end
  end

  // SCLK rising edges seen while selected, checked when CS_n releases.
  always @(posedge sclk[0] or posedge cs_n[0]) begin
    if (cs_n[0] === 1'b1) begin
      if (rst[0] === 1'b0) chk("sclk_rises_d2", rises0, 16);
      rises0 = 0;
    end else if (cs_n[0] === 1'b0) begin
      rises0++;
    end
  end

  always @(posedge sclk[1] or posedge cs_n[1]) begin
    if (cs_n[1] === 1'b1) begin
      if (rst[1] === 1'b0) chk("sclk_rises_d1", rises1, 16);
      rises1 = 0;
    end else if (cs_n[1] === 1'b0) begin
      rises1++;
    end
  end

  task automatic push_conv(input int d, input logic [15:0] w, input logic [11:0] ev, input int et);
    if (d == 0) begin
      adc_q0.push_back(w);
      if (et >= 0) begin exp_q0.push_back(ev); t_q0.push_back(et); end
    end else begin
      adc_q1.push_back(w);
      if (et >= 0) begin exp_q1.push_back(ev); t_q1.push_back(et); end
    end
  endtask

  task automatic mon_step(input int d);
    logic [11:0] ev;
    int          et;
    bit          have;
    if (rst[d] !== 1'b0) begin
      held[d]       = '0;
      prev_listo[d] = 1'b0;
    end else begin
      if (listo[d] === 1'b1) begin
        chk("listo_back_to_back", prev_listo[d], 0);
        have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        chk("listo_expected", have, 1);
        if (have) begin
          if (d == 0) begin ev = exp_q0.pop_front(); et = t_q0.pop_front(); end
          else begin ev = exp_q1.pop_front(); et = t_q1.pop_front(); end
          chk("listo_edge", edge_n, et);
          chk("dato_on_listo", dato[d], ev);
          held[d] = ev;
        end
      end else begin
        chk("dato_hold", dato[d], held[d]);
      end
      prev_listo[d] = listo[d];
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  // One conversion from idle; Listo/Dato are judged by the monitor.
  task automatic conv(input int d, input logic [15:0] w, input bit repulse);
    int dv;
    int s;
    dv = (d == 0) ? 2 : 1;
    @(negedge clk);
    chk("idle_before_start", ocup[d], 0);
    s = edge_n + 1;
    push_conv(d, w, w[11:0], s + 33 * dv);
    ini[d] = 1'b1;
    @(negedge clk);
    ini[d] = 1'b0;
    chk("cs_low_after_start", cs_n[d], 0);
    chk("ocupado_after_start", ocup[d], 1);
    chk("sclk_high_in_wait", sclk[d], 1);
    for (int e = 1; e <= 34 * dv + 1; e++) begin
      @(negedge clk);
      ini[d] = repulse && (e == 4 || e == 39);
      if (e < dv) chk("sclk_high_in_wait", sclk[d], 1);
      if (e == dv) chk("sclk_first_fall", sclk[d], 0);
      if (e == 33 * dv) chk("cs_low_during_listo", cs_n[d], 0);
      if (e == 33 * dv + 1) chk("cs_high_after_fin", cs_n[d], 1);
      if (e == 34 * dv) chk("ocupado_in_silence", ocup[d], 1);
      if (e == 34 * dv + 1) chk("ocupado_drop", ocup[d], 0);
    end
    ini[d] = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] hw [3];
    int          s;

    rst[0] = 1'b1; rst[1] = 1'b1;
    ini[0] = 1'b0; ini[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_sclk", sclk[d], 1);
      chk("rst_cs_n", cs_n[d], 1);
      chk("rst_ocupado", ocup[d], 0);
      chk("rst_listo", listo[d], 0);
      chk("rst_dato", dato[d], 0);
      chk("rst_estado", est[d], REPOSO);
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Directed frames, then one with Iniciar re-pulsed mid-conversion.
    conv(0, 16'h0AC3, 1'b0);
    conv(0, 16'hF001, 1'b0);
    conv(0, 16'($urandom), 1'b1);

    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      conv(0, 16'($urandom), 1'b0);
    end

    // Iniciar held high: back-to-back conversions every 70 edges.
    @(negedge clk);
    hw[0] = {4'($urandom), 12'hFFF};
    hw[1] = {4'($urandom), 12'h000};
    hw[2] = {4'($urandom), 12'h555};
    s = edge_n + 1;
    for (int k = 0; k < 3; k++) push_conv(0, hw[k], hw[k][11:0], s + 66 + 70 * k);
    ini[0] = 1'b1;
    for (int k = 0; k < 400 && edge_n < s + 206; k++) begin
      @(negedge clk);
      if (edge_n == s + 69 || edge_n == s + 139) chk("cs_high_between_convs", cs_n[0], 1);
      if (edge_n == s + 70 || edge_n == s + 140) chk("cs_low_restart", cs_n[0], 0);
    end
    ini[0] = 1'b0;
    for (int k = 0; k < 400 && edge_n < s + 212; k++) @(negedge clk);
    chk("no_fourth_conv", ocup[0], 0);

    // Asynchronous reset in the middle of a transfer.
    @(negedge clk);
    push_conv(0, 16'($urandom), 12'h0, -1);
    ini[0] = 1'b1;
    @(negedge clk);
    ini[0] = 1'b0;
    repeat (29) @(negedge clk);
    @(posedge clk);
    #3;
    rst[0] = 1'b1;
    #1;
    chk("abort_cs_n", cs_n[0], 1);
    chk("abort_sclk", sclk[0], 1);
    chk("abort_dato", dato[0], 0);
    chk("abort_listo", listo[0], 0);
    chk("abort_ocupado", ocup[0], 0);
    chk("abort_estado", est[0], REPOSO);
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    repeat (100) @(negedge clk);
    w = 16'($urandom);
    conv(0, w, 1'b0);

    // DIV=1 instance.
    conv(1, {4'($urandom), 12'h7FF}, 1'b0);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      conv(1, 16'($urandom), 1'b0);
    end

    repeat (10) @(negedge clk);
    chk("pending_listo_d2", exp_q0.size(), 0);
    chk("pending_listo_d1", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
